alu_cmd_driver: RTL

ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_cmd_fifo.sv | 65 ++++++
 rtl/alu_cmd_driver.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU command driver: opcode constants, FSM states and
// the packed command record carried through the command FIFO.
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_TAG_W  = 4;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_ARITH = 4'b0000;
    localparam opcode_t OP_LOGIC = 4'b0001;
    localparam opcode_t OP_CMP   = 4'b0010;
    localparam opcode_t OP_SHIFT = 4'b0011;
    localparam opcode_t OP_CLMUL = 4'b1001;
    localparam opcode_t OP_CRC   = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        opcode_t               opcode;
        logic [2:0]            funct;
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
        logic [ALU_TAG_W-1:0]  tag;
    } alu_cmd_t;

    localparam int ALU_CMD_W = $bits(alu_cmd_t);

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with registered full/empty flags and show-ahead read data.
// Pushes while full and pops while empty are ignored.
module alu_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - (AW+1)'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // NOTE: storage has no reset; the pointers and flags alone define which
    // entries are valid, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/alu_cmd_driver.sv
// Queues ALU commands, issues them one at a time, waits for the ALU response
// with a timeout, and presents each result in order on a valid/ready port.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int DATA_W    = ALU_DATA_W,
    parameter int TAG_W     = ALU_TAG_W,
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_opcode,
    input  logic [2:0]        cmd_funct,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic              alu_valid_i,
    output logic [3:0]        alu_opcode,
    output logic [2:0]        alu_funct,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_valid_o,
    input  logic [DATA_W-1:0] alu_o,
    input  logic              alu_overflow,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_overflow,
    output logic              res_timeout,
    output logic [TAG_W-1:0]  res_tag,
    output logic              busy,
    output logic [7:0]        stale_cnt
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    // The command record layout is fixed by the shared package.
    if (DATA_W != ALU_DATA_W || TAG_W != ALU_TAG_W) begin : g_width_guard
        $error("alu_cmd_driver: DATA_W/TAG_W must match alu_pkg");
    end

    state_t           state;
    state_t           state_next;
    alu_cmd_t         fifo_wr;
    alu_cmd_t         fifo_rd;
    alu_cmd_t         op_q;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             capture;
    logic             expire;
    logic [CNT_W-1:0] wait_cnt;

    assign cmd_ready = ~fifo_full & ~rst;
    assign fifo_push = cmd_valid & cmd_ready;
    assign fifo_wr   = '{opcode: cmd_opcode, funct: cmd_funct, a: cmd_a, b: cmd_b, tag: cmd_tag};

    alu_cmd_fifo #(
        .WIDTH (ALU_CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (fifo_wr),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                // A response on the final counter cycle still wins over the timeout.
                if (alu_valid_o) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    expire     = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (res_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q         <= '0;
            wait_cnt     <= '0;
            res_data     <= '0;
            res_overflow <= 1'b0;
            res_timeout  <= 1'b0;
            res_tag      <= '0;
            stale_cnt    <= '0;
        end else begin
            if (fifo_pop) op_q <= fifo_rd;

            if (state == ST_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
            else                  wait_cnt <= '0;

            if (capture) begin
                res_data     <= alu_o;
                res_overflow <= alu_overflow;
                res_timeout  <= 1'b0;
                res_tag      <= op_q.tag;
            end else if (expire) begin
                res_data     <= '0;
                res_overflow <= 1'b0;
                res_timeout  <= 1'b1;
                res_tag      <= op_q.tag;
            end

            // Responses outside WAIT belong to no outstanding operation.
            if (alu_valid_o && state != ST_WAIT && stale_cnt != 8'hFF) begin
                stale_cnt <= stale_cnt + 8'd1;
            end
        end
    end

    assign alu_valid_i = (state == ST_ISSUE);
    assign res_valid   = (state == ST_RESP);
    assign busy        = (state != ST_IDLE);
    assign alu_opcode  = op_q.opcode;
    assign alu_funct   = op_q.funct;
    assign alu_a       = op_q.a;
    assign alu_b       = op_q.b;

endmodule
